// File: rtl/grid_mem_ctl_if.sv
// Bus between the game-logic FSM / VGA renderer and grid_mem_ctl.
// Port A read/write, port B read-only, plus clear/collapse engine control.
interface grid_mem_ctl_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] data_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic                  we_a;
  logic [DATA_WIDTH-1:0] q_a;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  clr_start;
  logic                  col_start;
  logic [ADDR_WIDTH-1:0] col_row;
  logic                  busy;
  logic                  done;
  logic                  row_full;
  logic [ADDR_WIDTH-1:0] row_full_idx;

  modport master (
    output data_a, addr_a, we_a, addr_b, clr_start, col_start, col_row,
    input  q_a, q_b, busy, done, row_full, row_full_idx
  );

  modport slave (
    input  data_a, addr_a, we_a, addr_b, clr_start, col_start, col_row,
    output q_a, q_b, busy, done, row_full, row_full_idx
  );
endinterface

// File: rtl/grid_mem_ctl.sv
// Playfield row RAM with depth bounding, clear engine and line-collapse engine.
// Optional full-row detect strobe enabled by macro GRID_ROW_FULL_DETECT_EN.
module grid_mem_ctl #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 20
) (
  input  logic          clk,
  input  logic          rst,
  grid_mem_ctl_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LP_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_COL_RD,
    S_COL_WR,
    S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] w_idx_nxt;
  logic [DATA_WIDTH-1:0] r_buf;
  logic [DATA_WIDTH-1:0] w_buf_nxt;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_q_a;
  logic [DATA_WIDTH-1:0] r_q_b;

  logic                  w_busy;
  logic                  w_a_ok;
  logic                  w_b_ok;
  logic                  w_col_ok;
  logic                  w_a_acc;
  logic                  w_eng_we;
  logic [ADDR_WIDTH-1:0] w_eng_addr;
  logic [DATA_WIDTH-1:0] w_eng_data;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;

  assign w_busy   = (r_state == S_CLR) || (r_state == S_COL_RD) || (r_state == S_COL_WR);
  assign w_a_ok   = {1'b0, bus.addr_a}  < LP_DEPTH;
  assign w_b_ok   = {1'b0, bus.addr_b}  < LP_DEPTH;
  assign w_col_ok = {1'b0, bus.col_row} < LP_DEPTH;
  assign w_a_acc  = bus.we_a && !w_busy && w_a_ok;

  // Engine and port A never write together: port A is locked out while busy.
  assign w_we    = w_eng_we | w_a_acc;
  assign w_waddr = w_eng_we ? w_eng_addr : bus.addr_a;
  assign w_wdata = w_eng_we ? w_eng_data : bus.data_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_buf   <= w_buf_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_buf_nxt   = r_buf;
    w_eng_we    = 1'b0;
    w_eng_addr  = r_idx;
    w_eng_data  = '0;
    case (r_state)
      S_IDLE: begin
        if (bus.clr_start) begin
          w_state_nxt = S_CLR;
          w_idx_nxt   = '0;
        end else if (bus.col_start && w_col_ok) begin
          w_state_nxt = S_COL_RD;
          w_idx_nxt   = bus.col_row;
        end
      end
      S_CLR: begin
        w_eng_we = 1'b1;
        if (r_idx == LP_LAST) w_state_nxt = S_FIN;
        else                  w_idx_nxt   = r_idx + LP_ONE;
      end
      S_COL_RD: begin
        if (r_idx == '0) begin
          w_eng_we    = 1'b1;
          w_state_nxt = S_FIN;
        end else begin
          w_buf_nxt   = r_mem[r_idx - LP_ONE];
          w_state_nxt = S_COL_WR;
        end
      end
      S_COL_WR: begin
        w_eng_we    = 1'b1;
        w_eng_data  = r_buf;
        w_idx_nxt   = r_idx - LP_ONE;
        w_state_nxt = S_COL_RD;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the array has no reset; clearing it is the clear engine's job.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Both read ports are write-first against the single shared write path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q_a <= '0;
      r_q_b <= '0;
    end else begin
      if (!w_a_ok)                          r_q_a <= '0;
      else if (w_we && w_waddr == bus.addr_a) r_q_a <= w_wdata;
      else                                  r_q_a <= r_mem[bus.addr_a];

      if (!w_b_ok)                          r_q_b <= '0;
      else if (w_we && w_waddr == bus.addr_b) r_q_b <= w_wdata;
      else                                  r_q_b <= r_mem[bus.addr_b];
    end
  end

  assign bus.q_a  = r_q_a;
  assign bus.q_b  = r_q_b;
  assign bus.busy = w_busy;
  assign bus.done = (r_state == S_FIN);

`ifdef GRID_ROW_FULL_DETECT_EN
  logic                  r_row_full;
  logic [ADDR_WIDTH-1:0] r_row_full_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_full     <= 1'b0;
      r_row_full_idx <= '0;
    end else begin
      r_row_full <= w_a_acc && (&bus.data_a);
      if (w_a_acc && (&bus.data_a)) r_row_full_idx <= bus.addr_a;
    end
  end

  assign bus.row_full     = r_row_full;
  assign bus.row_full_idx = r_row_full_idx;
`else
  assign bus.row_full     = 1'b0;
  assign bus.row_full_idx = '0;
`endif

endmodule

// File: doc/grid_mem_ctl.md
Name: grid_mem_ctl

Overview:
- Parametrised successor to the team's dual-port grid RAM: one word per playfield row, one bit per cell.
- Adds depth bounding, a hardware clear engine and a line-collapse engine (shift rows down after a line clear), with busy/done handshake.
- Sits between game-logic FSM (port A read/write, engine control) and the VGA renderer (port B read-only).

Parameters:
- DATA_WIDTH, 10, bits per row (columns).
- ADDR_WIDTH, 5, row address width.
- DEPTH, 20, number of rows implemented; must be <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous active-high reset.
- data_a  in  DATA_WIDTH  port A write data.
- addr_a  in  ADDR_WIDTH  port A row address.
- we_a  in  1  port A write enable.
- q_a  out  DATA_WIDTH  port A registered read data.
- addr_b  in  ADDR_WIDTH  port B (renderer) row address.
- q_b  out  DATA_WIDTH  port B registered read data.
- clr_start  in  1  start full clear (pulse).
- col_start  in  1  start collapse of row col_row (pulse).
- col_row  in  ADDR_WIDTH  row to remove.
- busy  out  1  engine active.
- done  out  1  one-cycle pulse at engine completion.
- row_full  out  1  full-row detect strobe (optional feature).
- row_full_idx  out  ADDR_WIDTH  row that became full (optional feature).

Behaviour:
- Reset: q_a, q_b, busy, done, row_full, row_full_idx = 0; FSM -> IDLE. RAM contents not reset (initialised to 0 at time zero only).
- Port A: 1-cycle latency. Write-first: on write, q_a <= data_a next cycle. addr_a >= DEPTH: write dropped, q_a <= 0.
- Port B: 1-cycle latency. If any write (port A or engine) hits addr_b in same cycle, q_b <= written data. addr_b >= DEPTH: q_b <= 0.
- Ports A and B remain readable while busy; we_a ignored while busy (write dropped, q_a returns stored data).
- FSM states: IDLE, CLR, COL_RD, COL_WR, FIN.
- IDLE: clr_start -> CLR, idx=0. Else col_start with col_row < DEPTH -> COL_RD, idx=col_row. col_row >= DEPTH: request ignored, no busy, no done. clr_start has priority if both asserted. Starts ignored outside IDLE.
- CLR: write 0 to row idx each cycle; idx==DEPTH-1 -> FIN. Exactly DEPTH write cycles.
- COL_RD: idx==0 -> write 0 to row 0, -> FIN. Else latch mem[idx-1] into buffer -> COL_WR.
- COL_WR: write buffer to row idx, idx-1, -> COL_RD.
- Collapse of row R: 2R+1 engine cycles; rows 1..R receive old rows 0..R-1; row 0 cleared; rows > R untouched.
- FIN: done=1 for one cycle, -> IDLE. busy=1 in CLR, COL_RD, COL_WR; 0 in IDLE and FIN.
- Engine writes use same forwarding path to q_b as port A writes.
- Reset mid-operation: engine aborts immediately, no done; rows already written keep new values.

Optional Feature:
- Macro GRID_ROW_FULL_DETECT_EN.
- Defined: on an accepted port A write with data_a all ones, next cycle row_full=1 for one cycle and row_full_idx=addr_a; otherwise row_full=0, row_full_idx holds.
- Not defined: row_full and row_full_idx tied 0; no detect logic.

Test Plan:
- Write row 3 = 0x155, next cycle read addr_a=3 -> q_a=0x155 one cycle later; addr_a=25 write 0x3FF -> dropped, q_a=0.
- Port A write row 7 = 0x2AA with addr_b=7 same cycle -> q_b=0x2AA next cycle (forwarded).
- Fill rows 0..19 nonzero, pulse clr_start -> busy high 20 cycles, done pulse, all rows read 0.
- Rows 0..4 = 0x001,0x002,0x004,0x008,0x010, col_start row 3 -> 7 busy cycles, done; rows 0..4 = 0x000,0x001,0x002,0x004,0x010.
- Pulse clr_start at cycle 5 of collapse, and we_a to row 10 while busy -> both ignored, collapse completes normally, row 10 unchanged; rst at cycle 8 of a clear -> busy=0, no done, rows 0..7 zero, rest unchanged.
- With GRID_ROW_FULL_DETECT_EN: write 0x3FF to row 12 -> row_full=1 one cycle, row_full_idx=12; without macro -> row_full stays 0.
